// File: rtl/countdown_timer.sv
// Loadable down-counter with start/busy/done handshake.
// One-shot or periodic (auto_reload) terminal-count pulse generator.
module countdown_timer #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st,
    input  logic [BUS_WIDTH-1:0] X,
    input  logic                 en,
    input  logic                 auto_reload,
    input  logic                 stop,
    output logic [BUS_WIDTH-1:0] o,
    output logic                 busy,
    output logic                 done,
    output logic                 zero
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BUS_WIDTH-1:0] rl;
    logic [BUS_WIDTH-1:0] rl_nxt;
    logic [BUS_WIDTH-1:0] count_nxt;
    logic                 done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            o     <= '0;
            rl    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            o     <= count_nxt;
            rl    <= rl_nxt;
            done  <= done_nxt;
        end
    end

    // Priority: load beats abort beats counting; o==0 is never decremented.
    always_comb begin
        state_nxt = state;
        count_nxt = o;
        rl_nxt    = rl;
        done_nxt  = 1'b0;
        if (st) begin
            count_nxt = X;
            rl_nxt    = X;
            if (X != '0) begin
                state_nxt = RUN;
            end else begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end else if (state == RUN) begin
            if (stop) begin
                state_nxt = IDLE;
            end else if (en) begin
                if (o == BUS_WIDTH'(1)) begin
                    done_nxt = 1'b1;
                    if (auto_reload) begin
                        count_nxt = rl;
                    end else begin
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else if (o != '0) begin
                    count_nxt = o - BUS_WIDTH'(1);
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign zero = (o == '0);

endmodule
